// File: rtl/sharp_filter.sv
// sharp_filter: 3x3 sharpen (centre CENTER_W, neighbours -1) over an IMG_H x IMG_W
// grayscale image. The image is read once through the shared row/col port into three
// rolling line buffers. Each output row is filtered once the row below it is buffered,
// and the result is written back through the same port, which makes in-place
// write-back safe.
module sharp_filter #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int ADDR_W   = 6,
    parameter int CENTER_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [23:0]       in_pix,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              out_we,
    output logic [23:0]       out_pix,
    output logic              busy,
    output logic              filter_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_ADDR  = 3'd1;
    localparam logic [2:0] S_LD_SAMP  = 3'd2;
    localparam logic [2:0] S_FL_CALC  = 3'd3;
    localparam logic [2:0] S_FL_WRITE = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W-1:0] row_q,     row_d;
    logic [ADDR_W-1:0] col_q,     col_d;
    logic              out_we_q,  out_we_d;
    logic [23:0]       out_pix_q, out_pix_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // Three rolling row buffers; image row r lives in slot r mod 3.
    logic [7:0] line_buf [3][IMG_W];

    // Only the G channel is used.
    logic unused_pix_bits;
    assign unused_pix_bits = ^{in_pix[23:16], in_pix[7:0]};

    function automatic logic [1:0] slot_of(input logic [ADDR_W-1:0] r);
        return 2'(r % ADDR_W'(3));
    endfunction

    // Kernel evaluation at (row_q, col_q) with zero padding outside the image.
    int                 rr, cc, px, cpix, nsum, acc;
    logic signed [12:0] s;
    logic [7:0]         v;
    always_comb begin
        rr   = 0;
        cc   = 0;
        px   = 0;
        cpix = 0;
        nsum = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(row_q) + dr;
                cc = int'(col_q) + dc;
                px = 0;
                if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
                    px = int'(line_buf[slot_of(ADDR_W'(rr))][ADDR_W'(cc)]);
                if (dr == 0 && dc == 0) cpix = px;
                else                    nsum = nsum + px;
            end
        end
        acc = CENTER_W * cpix - nsum;
        s   = 13'(acc);
        if (s < 13'sd0)        v = 8'h00;
        else if (s > 13'sd255) v = 8'hFF;
        else                   v = s[7:0];
    end

    // Next-state logic: load/filter schedule and address sequencing.
    // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        out_we_d  = 1'b0;
        out_pix_d = out_pix_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LD_ADDR;
                    row_d   = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LD_ADDR: state_d = S_LD_SAMP;
            S_LD_SAMP: begin
                if (col_q == ADDR_W'(IMG_W - 1)) begin
                    col_d = '0;
                    if (row_q == '0 && IMG_H > 1) begin
                        state_d = S_LD_ADDR;
                        row_d   = ADDR_W'(1);
                    end else begin
                        state_d = S_FL_CALC;
                        row_d   = (row_q == '0) ? '0 : row_q - ADDR_W'(1);
                    end
                end else begin
                    col_d   = col_q + ADDR_W'(1);
                    state_d = S_LD_ADDR;
                end
            end
            S_FL_CALC: begin
                out_pix_d = {8'h00, v, 8'h00};
                out_we_d  = 1'b1;
                state_d   = S_FL_WRITE;
            end
            S_FL_WRITE: begin
                if (col_q == ADDR_W'(IMG_W - 1)) begin
                    col_d = '0;
                    if (int'(row_q) + 2 < IMG_H) begin
                        state_d = S_LD_ADDR;
                        row_d   = row_q + ADDR_W'(2);
                    end else if (int'(row_q) + 1 < IMG_H) begin
                        state_d = S_FL_CALC;
                        row_d   = row_q + ADDR_W'(1);
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    col_d   = col_q + ADDR_W'(1);
                    state_d = S_FL_CALC;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            out_we_q  <= 1'b0;
            out_pix_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_we_q  <= out_we_d;
            out_pix_q <= out_pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Line-buffer fill: capture G on the edge ending the sample cycle.
    // NOTE: the buffers carry no reset; each slot is rewritten before it is read in every pass.
    always_ff @(posedge clk) begin
        if (state_q == S_LD_SAMP)
            line_buf[slot_of(row_q)][col_q] <= in_pix[15:8];
    end

    assign row         = row_q;
    assign col         = col_q;
    assign out_we      = out_we_q;
    assign out_pix     = out_pix_q;
    assign busy        = busy_q;
    assign filter_done = done_q;

endmodule

// File: tb/tb_sharp_filter.sv
// tb_sharp_filter: directed checks of sharp_filter against an in-place image memory.
module tb_sharp_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] in_pix;
    logic [5:0]  row, col;
    logic        out_we;
    logic [23:0] out_pix;
    logic        busy, filter_done;

    logic [23:0] img  [64][64];
    int          wcnt [64][64];
    int          total_w;
    int          total = 0;
    int          bad   = 0;

    sharp_filter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_pix      (in_pix),
        .row         (row),
        .col         (col),
        .out_we      (out_we),
        .out_pix     (out_pix),
        .busy        (busy),
        .filter_done (filter_done)
    );

    always #5 clk = ~clk;

    // Combinational read port, write-back in place.
    assign in_pix = img[row][col];

    always @(posedge clk) begin
        if (out_we) begin
            img[row][col]  <= out_pix;
            wcnt[row][col] <= wcnt[row][col] + 1;
            total_w        <= total_w + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill image with a background value and clear write bookkeeping (called with clk low).
    task automatic load_image(input logic [23:0] bg);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                img[r][c]  = bg;
                wcnt[r][c] = 0;
            end
        total_w = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a pass, check busy rise, then wait (bounded) for filter_done.
    task automatic run_pass(input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 0;
        while (!filter_done && cyc < 16400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done_in_time"}, {31'd0, (filter_done && cyc <= 16392)}, 32'd1);
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int odd;
        odd = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (wcnt[r][c] != 1) odd++;
        check({tag, "_total_writes"}, total_w, 32'd4096);
        check({tag, "_addr_not_once"}, odd, 32'd0);
    endtask

    task automatic count_nonzero(input string tag, input int exp_n);
        int n;
        n = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (img[r][c] !== 24'h000000) n++;
        check({tag, "_nonzero_count"}, n, exp_n);
    endtask

    initial begin
        int w_snap;
        int guard;

        // Reset state
        load_image(24'h000000);
        #2;
        check("rst_row", {26'd0, row}, 32'd0);
        check("rst_col", {26'd0, col}, 32'd0);
        check("rst_out_we", {31'd0, out_we}, 32'd0);
        check("rst_out_pix", {8'd0, out_pix}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, filter_done}, 32'd0);
        do_reset();

        // Uniform G=100: interior 100, edges 400 and corners 600 clamp to 255
        load_image(24'h006400);
        run_pass("uniform");
        check_writes("uniform");
        check("uni_00",    {8'd0, img[0][0]},   32'h00FF00);
        check("uni_63_63", {8'd0, img[63][63]}, 32'h00FF00);
        check("uni_0_5",   {8'd0, img[0][5]},   32'h00FF00);
        check("uni_40_63", {8'd0, img[40][63]}, 32'h00FF00);
        check("uni_1_1",   {8'd0, img[1][1]},   32'h006400);
        check("uni_32_40", {8'd0, img[32][40]}, 32'h006400);
        check("uni_62_62", {8'd0, img[62][62]}, 32'h006400);

        // R=B=FF, G=0: everything out as zero, R/B forced to 0
        do_reset();
        load_image(24'hFF00FF);
        run_pass("rb");
        check_writes("rb");
        count_nonzero("rb", 0);
        check("rb_last_out_pix", {8'd0, out_pix}, 32'd0);

        // Reset during the 1000th write
        do_reset();
        load_image(24'h006400);
        start = 1'b1;
        guard = 0;
        while (!(out_we === 1'b1 && total_w == 999) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reach_1000th", {31'd0, (guard < 20000)}, 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort_out_we",  {31'd0, out_we}, 32'd0);
        check("abort_out_pix", {8'd0, out_pix}, 32'd0);
        check("abort_busy",    {31'd0, busy}, 32'd0);
        check("abort_row_col", {20'd0, row, col}, 32'd0);
        w_snap = total_w;
        repeat (5) @(negedge clk);
        check("abort_no_writes", total_w, w_snap);
        check("abort_count", w_snap, 32'd999);
        rst_n = 1'b1;

        // Fresh full pass after abort: sparse impulses
        load_image(24'h000000);
        img[10][10] = 24'h00FF00;
        img[0][0]   = 24'h00FF00;
        img[30][30] = 24'h001400;
        img[63][63] = 24'h000100;
        run_pass("impulse");
        check_writes("impulse");
        check("imp_10_10", {8'd0, img[10][10]}, 32'h00FF00);
        check("imp_9_9",   {8'd0, img[9][9]},   32'h000000);
        check("imp_11_10", {8'd0, img[11][10]}, 32'h000000);
        check("imp_10_11", {8'd0, img[10][11]}, 32'h000000);
        check("imp_0_0",   {8'd0, img[0][0]},   32'h00FF00);
        check("imp_1_1",   {8'd0, img[1][1]},   32'h000000);
        check("imp_30_30", {8'd0, img[30][30]}, 32'h00B400);
        check("imp_63_63", {8'd0, img[63][63]}, 32'h000900);
        count_nonzero("impulse", 4);

        // Terminal DONE: start held high is ignored
        w_snap = total_w;
        start = 1'b1;
        repeat (20000) @(posedge clk);
        #1;
        check("hold_no_writes", total_w, w_snap);
        check("hold_done", {31'd0, filter_done}, 32'd1);
        check("hold_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
